// File: rtl/timer_irq_apb_if.sv
// rtl/timer_irq_apb_if.sv - APB slave bus bundle for the timer interrupt stage
interface timer_irq_apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata
    );
endinterface

// File: rtl/timer_irq_apb.sv
// rtl/timer_irq_apb.sv - compare/terminal-count status flags and level interrupt for the APB timer
module timer_irq_apb #(
    parameter int NUM_CMP = 2,
    parameter int WRAP_W  = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    timer_irq_apb_if.slave        apb,
    input  logic [31:0]           tmr_count,
    input  logic [31:0]           tmr_load,
    input  logic                  tmr_en,
    input  logic                  tmr_mode,
    output logic                  irq
);
    // Status-layout bits that physically exist: one per compare channel plus TC at bit 8.
    localparam logic [8:0]        BIT_MASK = 9'h100 | 9'((1 << NUM_CMP) - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [31:0]       cmp [NUM_CMP];
    logic [8:0]        ctrl;
    logic [8:0]        ris;
    logic [8:0]        mask;
    logic [8:0]        match_q;
    logic [8:0]        m_lvl;
    logic [8:0]        m_evt;
    logic [8:0]        w1c;
    logic [WRAP_W-1:0] wraps;
    logic [5:0]        widx;
    logic              wr_en;
    logic              rd_setup;
    logic              rd_hold;
    logic [31:0]       rd_val;
    logic              unused_addr;

    assign widx        = apb.paddr[7:2];
    assign wr_en       = apb.psel & apb.pwrite & apb.penable;
    assign rd_setup    = apb.psel & ~apb.pwrite & ~apb.penable;
    assign rd_hold     = apb.psel & ~apb.pwrite & apb.penable;
    assign unused_addr = ^{apb.paddr[15:8], apb.paddr[1:0]};

    // Match levels: a channel only matches while enabled and the timer is counting.
    always_comb begin
        m_lvl = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            m_lvl[i] = ctrl[i] & tmr_en & (tmr_count == cmp[i]);
        end
        m_lvl[8] = ctrl[8] & tmr_en & (tmr_count == tmr_load);
    end

    // Only rising edges of a level count as events, so a parked match fires once.
    assign m_evt = m_lvl & ~match_q;
    assign w1c   = (wr_en && widx == 6'h05) ? (apb.pwdata[8:0] & BIT_MASK) : 9'd0;

    // Read mux; compare slots beyond NUM_CMP exist in the map but read as zero.
    always_comb begin
        rd_val = 32'hdeadbeaf;
        case (widx)
            6'h00, 6'h01, 6'h02, 6'h03: begin
                rd_val = '0;
                for (int i = 0; i < NUM_CMP; i++) begin
                    if (widx[1:0] == 2'(i)) begin
                        rd_val = cmp[i];
                    end
                end
            end
            6'h04:   rd_val = {23'd0, ctrl};
            6'h05:   rd_val = {23'd0, ris};
            6'h06:   rd_val = {23'd0, mask};
            6'h07:   rd_val = {23'd0, ris & mask};
            6'h08:   rd_val = 32'(wraps);
            default: ;
        endcase
    end

    // Compare value registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_CMP; i++) begin
                cmp[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CMP; i++) begin
                if (widx == 6'(i)) begin
                    cmp[i] <= apb.pwdata;
                end
            end
        end
    end

    // CTRL and MASK keep only the bits that have a channel behind them.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl <= '0;
            mask <= '0;
        end else if (wr_en) begin
            if (widx == 6'h04) begin
                ctrl <= apb.pwdata[8:0] & BIT_MASK;
            end
            if (widx == 6'h06) begin
                mask <= apb.pwdata[8:0] & BIT_MASK;
            end
        end
    end

    // Sticky status: a new event beats a simultaneous write-one-to-clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            match_q <= '0;
            ris     <= '0;
        end else begin
            match_q <= m_lvl;
            ris     <= (ris & ~w1c) | m_evt;
        end
    end

    // Interrupt follows the registered masked status one cycle later.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |(ris & mask);
        end
    end

    // Saturating count of reload-mode terminal counts; a clear write wins over an increment.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wraps <= '0;
        end else if (wr_en && widx == 6'h08) begin
            wraps <= '0;
        end else if (m_evt[8] && tmr_mode && wraps != WRAP_MAX) begin
            wraps <= wraps + WRAP_W'(1);
        end
    end

    // Read data captured in setup, held through access, zero otherwise.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb.prdata <= '0;
        end else if (rd_setup) begin
            apb.prdata <= rd_val;
        end else if (!rd_hold) begin
            apb.prdata <= '0;
        end
    end
endmodule

// File: tb/tb_timer_irq_apb.sv
// tb/tb_timer_irq_apb.sv - randomized model-checked bench for timer_irq_apb
module tb_timer_irq_apb;
    localparam int NUM_CMP = 2;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b1;
    logic [31:0] tmr_count = '0;
    logic [31:0] tmr_load  = '0;
    logic        tmr_en    = 1'b0;
    logic        tmr_mode  = 1'b0;
    logic        irq;
    logic        irq4;

    timer_irq_apb_if bus();
    timer_irq_apb_if bus4();

    assign bus4.psel    = bus.psel;
    assign bus4.penable = bus.penable;
    assign bus4.pwrite  = bus.pwrite;
    assign bus4.paddr   = bus.paddr;
    assign bus4.pwdata  = bus.pwdata;

    timer_irq_apb #(.NUM_CMP(NUM_CMP), .WRAP_W(16)) dut (
        .pclk(pclk), .presetn(presetn), .apb(bus),
        .tmr_count(tmr_count), .tmr_load(tmr_load), .tmr_en(tmr_en), .tmr_mode(tmr_mode),
        .irq(irq)
    );

    timer_irq_apb #(.NUM_CMP(NUM_CMP), .WRAP_W(4)) dut4 (
        .pclk(pclk), .presetn(presetn), .apb(bus4),
        .tmr_count(tmr_count), .tmr_load(tmr_load), .tmr_en(tmr_en), .tmr_mode(tmr_mode),
        .irq(irq4)
    );

    always #5 pclk = ~pclk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          tsel  = 0;

    logic [31:0] m_cmp [4];
    logic [8:0]  m_ctrl, m_ris, m_mask, m_prev;
    logic        m_irq;
    logic [31:0] m_pr, m_pr4;
    int unsigned m_w16, m_w4;

    logic [15:0] addrs [10] = '{16'h00, 16'h04, 16'h08, 16'h10, 16'h14,
                                16'h18, 16'h1C, 16'h20, 16'h24, 16'h110};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] keep(input logic [31:0] d);
        return {d[8], 6'b0, d[1:0]};
    endfunction

    function automatic logic [31:0] reg_val(input logic [5:0] ix, input int unsigned w);
        case (ix)
            6'd0:       return m_cmp[0];
            6'd1:       return m_cmp[1];
            6'd2, 6'd3: return 32'd0;
            6'd4:       return {23'd0, m_ctrl};
            6'd5:       return {23'd0, m_ris};
            6'd6:       return {23'd0, m_mask};
            6'd7:       return {23'd0, m_ris & m_mask};
            6'd8:       return w;
            default:    return 32'hdeadbeaf;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cmp[i] = '0;
        m_ctrl = '0; m_ris = '0; m_mask = '0; m_prev = '0;
        m_irq = 1'b0; m_pr = '0; m_pr4 = '0; m_w16 = 0; m_w4 = 0;
    endtask

    task automatic tick();
        logic [8:0]  lvl, ev, wclr, n_ris;
        logic        wr, rs, rh, n_irq;
        logic [5:0]  ix;
        logic [31:0] wd, n_pr, n_pr4;
        int unsigned n_w16, n_w4;
        lvl = '0;
        for (int i = 0; i < NUM_CMP; i++) lvl[i] = m_ctrl[i] && tmr_en && (tmr_count == m_cmp[i]);
        lvl[8] = m_ctrl[8] && tmr_en && (tmr_count == tmr_load);
        ev = lvl & ~m_prev;
        wr = bus.psel && bus.pwrite && bus.penable;
        rs = bus.psel && !bus.pwrite && !bus.penable;
        rh = bus.psel && !bus.pwrite && bus.penable;
        ix = bus.paddr[7:2];
        wd = bus.pwdata;
        wclr  = (wr && ix == 6'd5) ? keep(wd) : 9'd0;
        n_ris = (m_ris & ~wclr) | ev;
        n_irq = |(m_ris & m_mask);
        n_w16 = m_w16;
        n_w4  = m_w4;
        if (wr && ix == 6'd8) begin
            n_w16 = 0;
            n_w4  = 0;
        end else if (ev[8] && tmr_mode) begin
            if (n_w16 < 65535) n_w16++;
            if (n_w4 < 15) n_w4++;
        end
        if (rs) begin
            n_pr  = reg_val(ix, m_w16);
            n_pr4 = reg_val(ix, m_w4);
        end else if (rh) begin
            n_pr  = m_pr;
            n_pr4 = m_pr4;
        end else begin
            n_pr  = '0;
            n_pr4 = '0;
        end
        @(posedge pclk);
        m_prev = lvl; m_ris = n_ris; m_irq = n_irq;
        m_w16 = n_w16; m_w4 = n_w4; m_pr = n_pr; m_pr4 = n_pr4;
        if (wr) begin
            case (ix)
                6'd0:    m_cmp[0] = wd;
                6'd1:    m_cmp[1] = wd;
                6'd4:    m_ctrl = keep(wd);
                6'd6:    m_mask = keep(wd);
                default: ;
            endcase
        end
        @(negedge pclk);
        chk("irq", 32'(irq), 32'(m_irq));
        chk("irq_w4", 32'(irq4), 32'(m_irq));
        chk("prdata", bus.prdata, m_pr);
        chk("prdata_w4", bus4.prdata, m_pr4);
        case (tsel)
            1: if (tmr_en) begin
                if (tmr_count == tmr_load) begin
                    if (tmr_mode) tmr_count = '0;
                end else begin
                    tmr_count = tmr_count + 32'd1;
                end
            end
            2: begin
                tmr_count = 32'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) tmr_load = 32'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) tmr_mode = 1'($urandom_range(0, 1));
                tmr_en = ($urandom_range(0, 7) != 0);
            end
            default: ;
        endcase
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwdata = d;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic [31:0] d4);
        bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = a;
        tick();
        bus.penable = 1'b1;
        tick();
        d  = bus.prdata;
        d4 = bus4.prdata;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic do_reset();
        #2 presetn = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_irq_w4", 32'(irq4), 32'd0);
        chk("arst_prdata", bus.prdata, 32'd0);
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench stopped");
    end

    initial begin
        logic [31:0] r, r4, d;
        logic [15:0] a;
        int          op;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        model_reset();
        #1 presetn = 1'b0;
        #2;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_prdata", bus.prdata, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        tick();
        apb_read(16'h10, r, r4); chk("rst_ctrl", r, 32'd0);
        apb_read(16'h14, r, r4); chk("rst_ris", r, 32'd0);
        apb_read(16'h18, r, r4); chk("rst_mask", r, 32'd0);
        apb_read(16'h20, r, r4); chk("rst_wraps", r, 32'd0);

        // compare channel 0 hit and W1C
        apb_write(16'h00, 32'd5); apb_write(16'h10, 32'h1); apb_write(16'h18, 32'h1);
        tmr_load = 32'd20; tmr_mode = 1'b0; tmr_count = '0; tmr_en = 1'b1; tsel = 1;
        repeat (6) tick();
        chk("t1_irq_lag", 32'(irq), 32'd0);
        tick();
        chk("t1_irq_set", 32'(irq), 32'd1);
        apb_read(16'h14, r, r4); chk("t1_ris", r, 32'h1);
        apb_write(16'h14, 32'h1);
        chk("t1_irq_hold", 32'(irq), 32'd1);
        tick();
        chk("t1_irq_clr", 32'(irq), 32'd0);

        // one-shot parked at load fires once
        tmr_en = 1'b0; tsel = 0;
        apb_write(16'h10, 32'h100); apb_write(16'h14, 32'h1ff);
        apb_write(16'h18, 32'h100); apb_write(16'h20, 32'h0);
        tmr_load = 32'd3; tmr_mode = 1'b0; tmr_count = '0; tmr_en = 1'b1; tsel = 1;
        repeat (104) tick();
        chk("t2_irq", 32'(irq), 32'd1);
        apb_read(16'h14, r, r4); chk("t2_ris", r, 32'h100);
        apb_write(16'h14, 32'h100);
        repeat (20) tick();
        chk("t2_irq_off", 32'(irq), 32'd0);
        apb_read(16'h14, r, r4); chk("t2_ris_off", r, 32'h0);
        apb_read(16'h20, r, r4); chk("t2_wraps", r, 32'h0);

        // reload wraps and saturation
        tmr_en = 1'b0; tsel = 0;
        apb_write(16'h14, 32'h1ff); apb_write(16'h20, 32'h0);
        tmr_load = 32'd4; tmr_mode = 1'b1; tmr_count = '0; tmr_en = 1'b1; tsel = 1;
        repeat (50) tick();
        tmr_en = 1'b0; tsel = 0;
        apb_read(16'h20, r, r4); chk("t3_wraps10", r, 32'd10); chk("t3_wraps10_w4", r4, 32'd10);
        apb_write(16'h20, 32'h0);
        tmr_count = '0; tmr_en = 1'b1; tsel = 1;
        repeat (100) tick();
        tmr_en = 1'b0; tsel = 0;
        apb_read(16'h20, r, r4); chk("t3_wraps20", r, 32'd20); chk("t3_wraps_sat_w4", r4, 32'd15);
        tmr_count = 32'd3; tmr_en = 1'b1; tsel = 1;
        apb_write(16'h20, 32'h1234);
        tmr_en = 1'b0; tsel = 0;
        apb_read(16'h20, r, r4); chk("t3_clr_wins", r, 32'd0); chk("t3_clr_wins_w4", r4, 32'd0);

        // set beats W1C on the same edge
        apb_write(16'h04, 32'd7); apb_write(16'h10, 32'h2);
        apb_write(16'h18, 32'h2); apb_write(16'h14, 32'h1ff);
        tmr_count = 32'd7; tmr_en = 1'b1;
        tick();
        tmr_count = '0;
        tick();
        chk("t4_irq_pre", 32'(irq), 32'd1);
        tmr_load = 32'd20; tmr_mode = 1'b0; tmr_count = 32'd6; tsel = 1;
        apb_write(16'h14, 32'h2);
        tsel = 0; tmr_en = 1'b0;
        chk("t4_irq", 32'(irq), 32'd1);
        tick();
        chk("t4_irq_stay", 32'(irq), 32'd1);
        apb_read(16'h14, r, r4); chk("t4_ris", r, 32'h2);

        // read map corners and idle/write prdata
        apb_write(16'h10, 32'hffffffff);
        apb_read(16'h10, r, r4); chk("t5_ctrl", r, 32'h103);
        apb_read(16'h24, r, r4); chk("t5_hole", r, 32'hdeadbeaf);
        apb_read(16'h08, r, r4); chk("t5_cmp2", r, 32'h0);
        tick();
        chk("t5_idle_pr", bus.prdata, 32'h0);
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0; bus.paddr = 16'h18; bus.pwdata = '0;
        tick();
        chk("t5_wr_setup_pr", bus.prdata, 32'h0);
        bus.penable = 1'b1;
        tick();
        chk("t5_wr_access_pr", bus.prdata, 32'h0);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;

        // asynchronous reset mid-operation
        apb_write(16'h00, 32'd5); apb_write(16'h10, 32'h101);
        apb_write(16'h18, 32'h101); apb_write(16'h14, 32'h1ff);
        tmr_load = 32'd5; tmr_count = 32'd5; tmr_en = 1'b1;
        tick(); tick();
        chk("t6_irq_pre", 32'(irq), 32'd1);
        apb_read(16'h1C, r, r4); chk("t6_mis", r, 32'h101);
        bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = 16'h14;
        tick();
        chk("t6_pr_pre", bus.prdata, 32'h101);
        do_reset();
        bus.psel = 1'b0;
        apb_read(16'h14, r, r4); chk("t6_ris_rst", r, 32'h0);
        apb_read(16'h10, r, r4); chk("t6_ctrl_rst", r, 32'h0);
        apb_read(16'h00, r, r4); chk("t6_cmp0_rst", r, 32'h0);
        apb_write(16'h00, 32'd5); apb_write(16'h10, 32'h101);
        tick();
        apb_read(16'h14, r, r4); chk("t6_ris_reset", r, 32'h101);
        apb_write(16'h14, 32'h101);
        repeat (10) tick();
        apb_read(16'h14, r, r4); chk("t6_ris_once", r, 32'h0);

        // randomized traffic against the model
        tsel = 2;
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 3));
            a  = addrs[$urandom_range(0, 9)];
            d  = (a[7:2] < 6'd4) ? 32'($urandom_range(0, 7)) : $urandom;
            case (op)
                0:       apb_write(a, d);
                1:       apb_read(a, r, r4);
                default: tick();
            endcase
        end
        tsel = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
